// File: rtl/rng_pkg.sv
// Shared types and helpers for the rng_lfsr_gen entropy source.
// Defines the FSM encoding, the health repeat limit and a single LFSR step.
package rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } rng_state_e;

  localparam int unsigned HEALTH_REP_LIMIT = 4;
  localparam int unsigned LFSR_MAX_W       = 256;

  // One Fibonacci step on the low `width` bits; bits above width must be zero.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] poly,
    input int unsigned           width
  );
    logic                  fb;
    logic [LFSR_MAX_W-1:0] fb_vec;
    fb     = ^(poly & state);
    fb_vec = {{(LFSR_MAX_W-1){1'b0}}, fb} << (width - 32'd1);
    return (state >> 1) | fb_vec;
  endfunction

endpackage

// File: rtl/rng_lfsr_core.sv
// LFSR state and tap-mask registers with STEPS_PER_CYC unrolled steps per clock.
// A zero seed or an all-zero next state is replaced by DEFAULT_SEED.
module rng_lfsr_core
  import rng_pkg::*;
#(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned STEPS_PER_CYC = 1,
  parameter logic [63:0] DEFAULT_SEED  = 64'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_advance,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [WIDTH-1:0] i_poly,
  output logic [WIDTH-1:0] o_next,
  output logic             o_next_zero,
  output logic             o_seed_zero
);

  localparam logic [WIDTH-1:0] SUB_SEED = WIDTH'(DEFAULT_SEED);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_poly;
  logic [WIDTH-1:0] w_chain [STEPS_PER_CYC+1];
  logic [WIDTH-1:0] w_raw;

  assign w_chain[0] = r_state;

  for (genvar g = 0; g < STEPS_PER_CYC; g++) begin : g_step
    assign w_chain[g+1] = WIDTH'(lfsr_step(LFSR_MAX_W'(w_chain[g]), LFSR_MAX_W'(r_poly), WIDTH));
  end

  assign w_raw       = w_chain[STEPS_PER_CYC];
  assign o_next_zero = (w_raw == {WIDTH{1'b0}});
  assign o_seed_zero = (i_seed == {WIDTH{1'b0}});
  assign o_next      = o_next_zero ? SUB_SEED : w_raw;

  // State and tap mask; a load always overrides stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= {WIDTH{1'b0}};
      r_poly  <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_state <= o_seed_zero ? SUB_SEED : i_seed;
      r_poly  <= i_poly;
    end else if (i_advance) begin
      r_state <= o_next;
    end else begin
      r_state <= r_state;
    end
  end

endmodule

// File: rtl/rng_lfsr_gen.sv
// rng_lfsr_gen: LFSR entropy source with warm-up, decimation, valid/ready output and sticky flags.
// Define RNG_HEALTH_EN to build the repetition-count health test; otherwise health_fail_o is 0.
module rng_lfsr_gen
  import rng_pkg::*;
#(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned STEPS_PER_CYC = 1,
  parameter int unsigned DECIM         = 1,
  parameter int unsigned WARMUP_CYC    = 0,
  parameter logic [63:0] DEFAULT_SEED  = 64'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [WIDTH-1:0] poly_i,
  output logic [WIDTH-1:0] rand_o,
  output logic             rand_valid_o,
  input  logic             rand_ready_i,
  input  logic             clr_flags_i,
  output logic             overrun_o,
  output logic             lockup_o,
  output logic             health_fail_o
);

  localparam logic [7:0]  DEC_LAST  = 8'(DECIM - 32'd1);
  localparam logic [9:0]  WARM_LAST = 10'(WARMUP_CYC - 32'd1);
  localparam rng_state_e  LOAD_NEXT = (WARMUP_CYC > 32'd0) ? ST_WARMUP : ST_RUN;

  rng_state_e       r_fsm;
  logic [9:0]       r_warm_cnt;
  logic [7:0]       r_dec_cnt;
  logic [WIDTH-1:0] r_rand;
  logic             r_valid;
  logic             r_overrun;
  logic             r_lockup;

  logic [WIDTH-1:0] w_next;
  logic             w_next_zero;
  logic             w_seed_zero;
  logic             w_advance;
  logic             w_wrap;
  logic             w_prod;
  logic             w_health_block;
  logic             w_lock_set;

  assign w_advance  = (r_fsm != ST_IDLE) && !load_i;
  assign w_wrap     = (r_fsm == ST_RUN) && (r_dec_cnt == DEC_LAST) && !load_i;
  assign w_prod     = w_wrap && !w_health_block;
  assign w_lock_set = (load_i && w_seed_zero) || (w_advance && w_next_zero);

  rng_lfsr_core #(
    .WIDTH        (WIDTH),
    .STEPS_PER_CYC(STEPS_PER_CYC),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (load_i),
    .i_advance  (w_advance),
    .i_seed     (seed_i),
    .i_poly     (poly_i),
    .o_next     (w_next),
    .o_next_zero(w_next_zero),
    .o_seed_zero(w_seed_zero)
  );

  // Sequencer: load restarts warm-up/decimation from zero in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm      <= ST_IDLE;
      r_warm_cnt <= 10'd0;
      r_dec_cnt  <= 8'd0;
    end else if (load_i) begin
      r_fsm      <= LOAD_NEXT;
      r_warm_cnt <= 10'd0;
      r_dec_cnt  <= 8'd0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          r_fsm <= ST_IDLE;
        end
        ST_WARMUP: begin
          if (r_warm_cnt == WARM_LAST) begin
            r_fsm      <= ST_RUN;
            r_warm_cnt <= 10'd0;
          end else begin
            r_warm_cnt <= r_warm_cnt + 10'd1;
          end
        end
        ST_RUN: begin
          r_dec_cnt <= (r_dec_cnt == DEC_LAST) ? 8'd0 : r_dec_cnt + 8'd1;
        end
        default: begin
          r_fsm      <= ST_IDLE;
          r_warm_cnt <= 10'd0;
          r_dec_cnt  <= 8'd0;
        end
      endcase
    end
  end

  // Output word: a new word may replace the current one only in the cycle it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rand  <= {WIDTH{1'b0}};
      r_valid <= 1'b0;
    end else if (load_i) begin
      r_valid <= 1'b0;
    end else if (w_prod && (!r_valid || rand_ready_i)) begin
      r_rand  <= w_next;
      r_valid <= 1'b1;
    end else if (r_valid && rand_ready_i) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Sticky flags: a set event in the same cycle as clr_flags_i keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
      r_lockup  <= 1'b0;
    end else begin
      r_overrun <= (w_prod && r_valid && !rand_ready_i) || (r_overrun && !clr_flags_i);
      r_lockup  <= w_lock_set || (r_lockup && !clr_flags_i);
    end
  end

`ifdef RNG_HEALTH_EN
  localparam logic [2:0] REP_LIMIT = 3'(HEALTH_REP_LIMIT);

  logic [WIDTH-1:0] r_last_word;
  logic [2:0]       r_rep_cnt;
  logic [2:0]       w_rep_next;
  logic             r_health_fail;

  // Length of the run of identical produced words including the current one.
  always_comb begin
    w_rep_next = 3'd1;
    if ((r_rep_cnt != 3'd0) && (w_next == r_last_word)) begin
      w_rep_next = (r_rep_cnt == REP_LIMIT) ? REP_LIMIT : r_rep_cnt + 3'd1;
    end else begin
      w_rep_next = 3'd1;
    end
  end

  // Repeat tracker; a count of zero means no word since the last load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_word <= {WIDTH{1'b0}};
      r_rep_cnt   <= 3'd0;
    end else if (load_i) begin
      r_rep_cnt <= 3'd0;
    end else if (w_prod) begin
      r_last_word <= w_next;
      r_rep_cnt   <= w_rep_next;
    end else begin
      r_rep_cnt <= r_rep_cnt;
    end
  end

  // Health alarm latches on the word that completes the repeat run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_health_fail <= 1'b0;
    end else begin
      r_health_fail <= (w_prod && (w_rep_next == REP_LIMIT)) || (r_health_fail && !clr_flags_i);
    end
  end

  assign w_health_block = r_health_fail;
  assign health_fail_o  = r_health_fail;
`else
  assign w_health_block = 1'b0;
  assign health_fail_o  = 1'b0;
`endif

  assign rand_o       = r_rand;
  assign rand_valid_o = r_valid;
  assign overrun_o    = r_overrun;
  assign lockup_o     = r_lockup;

endmodule
